vram_painter: RTL and testbench
===============================

VRAM_PAINTER -- requirements
Module: vram_painter

Interface
REQ-001 Parameters SHALL be: DISPLAY_WIDTH, default 240, pixels per row; DISPLAY_HEIGHT, default 320, rows; VRAM_L, default DISPLAY_WIDTH*DISPLAY_HEIGHT, VRAM words; BRUSH_LOG2, default 2, brush edge = 2^BRUSH_LOG2 pixels.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ena  input  1  advance enable; when low, all state holds and no write is issued.
REQ-005 touch  input  touch_t  current touch event (valid, x[8:0], y[8:0]).
REQ-006 clear_req  input  1  level request to blank VRAM.
REQ-007 color  input  16  ILI9341_color_t brush colour, sampled when a touch is accepted.
REQ-008 vram_wr_ena  output  1  VRAM write strobe.
REQ-009 vram_wr_addr  output  $clog2(VRAM_L)  write address, y*DISPLAY_WIDTH+x.
REQ-010 vram_wr_data  output  16  write data.
REQ-011 busy  output  1  high in any state other than S_IDLE.

Function
REQ-012 FSM states SHALL be S_CLEAR, S_IDLE and S_PAINT.
REQ-013 vram_wr_ena SHALL be combinational: ena & (state==S_CLEAR | state==S_PAINT). Address and data SHALL be valid in the same cycle.
REQ-014 In S_CLEAR, each ena cycle SHALL write BLACK (16'h0000) at clear_addr, then increment clear_addr. Addresses run 0..VRAM_L-1, exactly VRAM_L writes. After the write at VRAM_L-1: S_IDLE, clear_addr=0.
REQ-015 Touch acceptance in S_IDLE requires ena & touch.valid & x<DISPLAY_WIDTH & y<DISPLAY_HEIGHT, and block (x>>BRUSH_LOG2, y>>BRUSH_LOG2) != last block, or last_valid==0.
REQ-016 On acceptance: latch block origin and color; set last block and last_valid=1; next state S_PAINT. The first write SHALL occur on the next ena cycle.
REQ-017 S_PAINT SHALL write 2^(2*BRUSH_LOG2) pixels (16 by default), one per ena cycle, row-major: dx fastest, dy slowest, both starting at 0. After the last write: S_IDLE.
REQ-018 Paint addresses SHALL be (by*2^BRUSH_LOG2+dy)*DISPLAY_WIDTH + bx*2^BRUSH_LOG2+dx, with no out-of-range address. DISPLAY_WIDTH and DISPLAY_HEIGHT are multiples of 2^BRUSH_LOG2, so no clipping is required.
REQ-019 touch.valid low in S_IDLE with ena high SHALL clear last_valid.
REQ-020 Touch events arriving in S_PAINT or S_CLEAR SHALL be ignored; they are not queued.
REQ-021 When clear_req and a touch arrive together in S_IDLE, clear SHALL win.
REQ-022 Every clear SHALL reset last_valid to 0.
REQ-023 Widths: internal counters and block coordinates SHALL be sized with $clog2 of their range. Address arithmetic SHALL be at least $clog2(VRAM_L) bits with no truncation before the final assignment.

Reset
REQ-024 On rst: state=S_CLEAR, clear_addr=0, dx=dy=0, last_valid=0, clear_pending=0, latched colour=16'h0000. This gives a full VRAM blank after every reset.
REQ-025 Outputs during rst and the cycle after: vram_wr_ena follows REQ-013 and vram_wr_addr=0. busy=1 until the reset-time clear completes.
REQ-026 rst asserted mid-paint or mid-clear SHALL abandon the operation and restart per REQ-024.

Configuration
REQ-027 Macro VRAM_PAINTER_CLEAR_REQ_EN.
- Defined: clear_req in S_IDLE with ena SHALL enter S_CLEAR. clear_req during S_PAINT SHALL set clear_pending; after the paint completes, the FSM SHALL go directly to S_CLEAR and clear clear_pending. clear_req during S_CLEAR SHALL be ignored.
- Undefined: clear_req SHALL be ignored, and the only clear is the reset-time clear.

Verification
REQ-028 Reset, ena=1, no touch -> exactly 76800 writes of 16'h0000 at addresses 0..76799 in order; busy falls the cycle after address 76799.
REQ-029 Idle, touch {valid=1, x=10, y=5}, color=16'hF800 -> 16 writes of 16'hF800 at addresses 968..971, 1208..1211, 1448..1451, 1688..1691 in that order; then idle.
REQ-030 Touch held at x=10,y=5, then moved to x=11,y=6 (same block) -> no further writes. Then touch.valid=0 for one cycle and the same point reasserted -> one repaint of 16 writes.
REQ-031 ena toggling 1,0,1,0 during S_PAINT -> exactly 16 writes total, none in ena-low cycles, order per REQ-029.
REQ-032 With VRAM_PAINTER_CLEAR_REQ_EN: clear_req pulsed during write 5 of a paint -> remaining 11 paint writes, then 76800 black writes starting at address 0. Without the macro -> paint only, no clear.
REQ-033 Touch x=240,y=0 or x=0,y=320 -> no writes; last_valid unchanged.

Source files
------------

// File: rtl/vram_painter.sv
// vram_painter: blanks VRAM after reset, then stamps a square brush at each new touch block.
// Optional feature: define VRAM_PAINTER_CLEAR_REQ_EN to let clear_req trigger a VRAM blank.

package vram_painter_pkg;
  typedef logic [15:0] ILI9341_color_t;

  typedef struct packed {
    logic       valid;
    logic [8:0] x;
    logic [8:0] y;
  } touch_t;

  localparam ILI9341_color_t BLACK = 16'h0000;
endpackage

module vram_painter
  import vram_painter_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = 240,
  parameter int DISPLAY_HEIGHT = 320,
  parameter int VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
  parameter int BRUSH_LOG2     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  touch_t                    touch,
  input  logic                      clear_req,
  input  ILI9341_color_t            color,
  output logic                      vram_wr_ena,
  output logic [$clog2(VRAM_L)-1:0] vram_wr_addr,
  output ILI9341_color_t            vram_wr_data,
  output logic                      busy
);

  localparam int AW    = $clog2(VRAM_L);
  localparam int BRUSH = 1 << BRUSH_LOG2;
  localparam int DW    = (BRUSH_LOG2 > 0) ? BRUSH_LOG2 : 1;
  localparam int BXR   = $clog2(DISPLAY_WIDTH / BRUSH);
  localparam int BYR   = $clog2(DISPLAY_HEIGHT / BRUSH);
  localparam int BXW   = (BXR > 0) ? BXR : 1;
  localparam int BYW   = (BYR > 0) ? BYR : 1;

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_PAINT = 2'd2;

  localparam logic [AW-1:0] ADDR_ZERO  = {AW{1'b0}};
  localparam logic [AW-1:0] ADDR_ONE   = AW'(1);
  localparam logic [AW-1:0] CLEAR_LAST = AW'(VRAM_L - 1);
  localparam logic [AW-1:0] WIDTH_A    = AW'(DISPLAY_WIDTH);
  localparam logic [DW-1:0] D_ZERO     = {DW{1'b0}};
  localparam logic [DW-1:0] D_ONE      = DW'(1);
  localparam logic [DW-1:0] D_MAX      = DW'(BRUSH - 1);
  localparam logic [31:0]   WIDTH_U    = DISPLAY_WIDTH;
  localparam logic [31:0]   HEIGHT_U   = DISPLAY_HEIGHT;

  logic [1:0]     state_r;
  logic [AW-1:0]  clear_addr_r;
  logic [DW-1:0]  dx_r;
  logic [DW-1:0]  dy_r;
  logic [BXW-1:0] bx_r;
  logic [BYW-1:0] by_r;
  logic [BXW-1:0] last_bx_r;
  logic [BYW-1:0] last_by_r;
  logic           last_valid_r;
  logic           clear_pending_r;
  ILI9341_color_t color_r;

  logic [BXW-1:0] touch_bx_s;
  logic [BYW-1:0] touch_by_s;
  logic           in_range_s;
  logic           new_block_s;
  logic           clear_hit_s;
  logic           paint_last_s;
  logic [AW-1:0]  row_s;
  logic [AW-1:0]  col_s;
  logic [AW-1:0]  paint_addr_s;

  assign touch_bx_s   = BXW'(touch.x >> BRUSH_LOG2);
  assign touch_by_s   = BYW'(touch.y >> BRUSH_LOG2);
  assign in_range_s   = ({23'd0, touch.x} < WIDTH_U) && ({23'd0, touch.y} < HEIGHT_U);
  assign new_block_s  = !last_valid_r || (touch_bx_s != last_bx_r) || (touch_by_s != last_by_r);
  assign paint_last_s = (dx_r == D_MAX) && (dy_r == D_MAX);

  // Block origin times brush edge is a bit concatenation because the brush edge is a power of two.
  assign row_s        = AW'({by_r, dy_r});
  assign col_s        = AW'({bx_r, dx_r});
  assign paint_addr_s = (row_s * WIDTH_A) + col_s;

`ifdef VRAM_PAINTER_CLEAR_REQ_EN
  assign clear_hit_s = clear_req;
`else
  logic unused_clear_req_s;
  assign unused_clear_req_s = clear_req;
  assign clear_hit_s        = 1'b0;
`endif

  assign busy = (state_r != S_IDLE);

  // Write port: strobe follows state and ena; address and data are forced to zero/black during rst.
  always_comb begin
    vram_wr_ena  = 1'b0;
    vram_wr_addr = ADDR_ZERO;
    vram_wr_data = BLACK;
    case (state_r)
      S_CLEAR: begin
        vram_wr_ena = ena;
        if (rst) begin
          vram_wr_addr = ADDR_ZERO;
        end else begin
          vram_wr_addr = clear_addr_r;
        end
      end
      S_PAINT: begin
        vram_wr_ena = ena;
        if (rst) begin
          vram_wr_addr = ADDR_ZERO;
          vram_wr_data = BLACK;
        end else begin
          vram_wr_addr = paint_addr_s;
          vram_wr_data = color_r;
        end
      end
      default: begin
        vram_wr_ena  = 1'b0;
        vram_wr_addr = ADDR_ZERO;
        vram_wr_data = BLACK;
      end
    endcase
  end

  // Controller state: clear sweep, touch acceptance and brush raster.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= S_CLEAR;
      clear_addr_r    <= ADDR_ZERO;
      dx_r            <= D_ZERO;
      dy_r            <= D_ZERO;
      bx_r            <= {BXW{1'b0}};
      by_r            <= {BYW{1'b0}};
      last_bx_r       <= {BXW{1'b0}};
      last_by_r       <= {BYW{1'b0}};
      last_valid_r    <= 1'b0;
      clear_pending_r <= 1'b0;
      color_r         <= BLACK;
    end else if (ena) begin
      case (state_r)
        S_CLEAR: begin
          last_valid_r    <= 1'b0;
          clear_pending_r <= 1'b0;
          if (clear_addr_r == CLEAR_LAST) begin
            clear_addr_r <= ADDR_ZERO;
            state_r      <= S_IDLE;
          end else begin
            clear_addr_r <= clear_addr_r + ADDR_ONE;
          end
        end
        S_IDLE: begin
          if (clear_hit_s) begin
            state_r      <= S_CLEAR;
            clear_addr_r <= ADDR_ZERO;
            last_valid_r <= 1'b0;
          end else if (!touch.valid) begin
            last_valid_r <= 1'b0;
          end else if (in_range_s && new_block_s) begin
            bx_r         <= touch_bx_s;
            by_r         <= touch_by_s;
            last_bx_r    <= touch_bx_s;
            last_by_r    <= touch_by_s;
            last_valid_r <= 1'b1;
            color_r      <= color;
            dx_r         <= D_ZERO;
            dy_r         <= D_ZERO;
            state_r      <= S_PAINT;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_PAINT: begin
          if (clear_hit_s) begin
            clear_pending_r <= 1'b1;
          end
          if (dx_r == D_MAX) begin
            dx_r <= D_ZERO;
            dy_r <= dy_r + D_ONE;
          end else begin
            dx_r <= dx_r + D_ONE;
          end
          // A request landing on the final write still diverts straight into the clear.
          if (paint_last_s) begin
            dy_r <= D_ZERO;
            if (clear_pending_r || clear_hit_s) begin
              state_r         <= S_CLEAR;
              clear_addr_r    <= ADDR_ZERO;
              clear_pending_r <= 1'b0;
              last_valid_r    <= 1'b0;
            end else begin
              state_r <= S_IDLE;
            end
          end
        end
        default: begin
          state_r      <= S_CLEAR;
          clear_addr_r <= ADDR_ZERO;
          last_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_painter.sv
// Directed self-checking bench for vram_painter: reset blank, brush painting, block
// de-duplication, range rejection, ena gating, clear_req handling and reset mid-paint.
module tb_vram_painter;
  import vram_painter_pkg::*;

  localparam int W  = 240;
  localparam int H  = 320;
  localparam int VL = W * H;
  localparam int AW = $clog2(VL);

  logic           clk;
  logic           rst;
  logic           ena;
  touch_t         touch;
  logic           clear_req;
  ILI9341_color_t color;
  logic           vram_wr_ena;
  logic [AW-1:0]  vram_wr_addr;
  ILI9341_color_t vram_wr_data;
  logic           busy;

  int            checks;
  int            errors;
  logic [AW-1:0] wa_q[$];
  logic [15:0]   wd_q[$];
  bit            log_en;
  int            ena_low_writes;
  logic          busy_s;

  vram_painter dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .touch        (touch),
    .clear_req    (clear_req),
    .color        (color),
    .vram_wr_ena  (vram_wr_ena),
    .vram_wr_addr (vram_wr_addr),
    .vram_wr_data (vram_wr_data),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sample what the DUT presents for the coming rising edge, log writes, move to next negedge.
  task automatic tick();
    #1;
    busy_s = busy;
    if (log_en && vram_wr_ena !== 1'b0) begin
      wa_q.push_back(vram_wr_addr);
      wd_q.push_back(vram_wr_data);
      if (!ena) ena_low_writes++;
    end
    @(negedge clk);
  endtask

  task automatic clr_log();
    wa_q.delete();
    wd_q.delete();
    ena_low_writes = 0;
  endtask

  task automatic wait_idle(input int max_cyc, output int n);
    n = 0;
    tick();
    while (busy_s === 1'b1 && n < max_cyc) begin
      n++;
      tick();
    end
    check("idle_reached", {31'd0, busy_s}, 32'd0);
  endtask

  task automatic set_touch(input logic v, input int x, input int y);
    touch.valid = v;
    touch.x     = 9'(x);
    touch.y     = 9'(y);
  endtask

  task automatic check_paint(input string tag, input int x0, input int y0, input logic [15:0] col);
    check({tag, "_cnt"}, wa_q.size(), 32'd16);
    for (int i = 0; i < 16 && i < wa_q.size(); i++) begin
      check({tag, "_addr"}, wa_q[i], (y0 + i / 4) * W + x0 + i % 4);
      check({tag, "_data"}, wd_q[i], col);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int bad;
    int k;
    int hi_busy;
    checks = 0; errors = 0; log_en = 1'b0; ena_low_writes = 0; busy_s = 1'b0;
    rst = 1'b1; ena = 1'b1; clear_req = 1'b0; color = 16'h0000;
    set_touch(1'b0, 0, 0);

    // Reset state
    @(negedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_wen", {31'd0, vram_wr_ena}, 32'd1);
    check("rst_addr", vram_wr_addr, 32'd0);
    check("rst_data", vram_wr_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    log_en = 1'b1;

    // Reset-time clear: 76800 black writes in order, busy drops right after the last
    wait_idle(80000, n);
    check("clr_busy_cyc", n, 32'd76800);
    check("clr_cnt", wa_q.size(), 32'd76800);
    bad = 0;
    for (int i = 0; i < wa_q.size(); i++) begin
      if (wa_q[i] !== AW'(i) || wd_q[i] !== 16'h0000) bad++;
    end
    check("clr_seq_bad", bad, 32'd0);
    if (wa_q.size() > 0) begin
      check("clr_first", wa_q[0], 32'd0);
      check("clr_last", wa_q[wa_q.size() - 1], 32'd76799);
    end

    // Touch (10,5) red
    clr_log();
    color = 16'hF800;
    set_touch(1'b1, 10, 5);
    tick();
    check("p1_accept_busy", {31'd0, busy_s}, 32'd0);
    wait_idle(40, n);
    check("p1_busy_cyc", n, 32'd16);
    check_paint("p1", 8, 4, 16'hF800);
    if (wa_q.size() == 16) begin
      check("p1_first", wa_q[0], 32'd968);
      check("p1_row1", wa_q[4], 32'd1208);
      check("p1_last", wa_q[15], 32'd1691);
    end

    // Held, then moved within the same block: nothing new
    clr_log();
    repeat (3) tick();
    set_touch(1'b1, 11, 6);
    repeat (4) tick();
    check("hold_writes", wa_q.size(), 32'd0);
    check("hold_busy", {31'd0, busy_s}, 32'd0);

    // Lift for one cycle, then same point again: one repaint
    set_touch(1'b0, 10, 5);
    tick();
    set_touch(1'b1, 10, 5);
    tick();
    wait_idle(40, n);
    check_paint("rep", 8, 4, 16'hF800);

    // Out-of-range points: no writes and last block/valid untouched
    clr_log();
    set_touch(1'b1, 240, 0);
    repeat (3) tick();
    set_touch(1'b1, 0, 320);
    repeat (3) tick();
    set_touch(1'b1, 10, 5);
    repeat (3) tick();
    check("oor_writes", wa_q.size(), 32'd0);

    // Bottom-right corner block
    clr_log();
    color = 16'h07E0;
    set_touch(1'b1, 239, 319);
    tick();
    wait_idle(40, n);
    check_paint("br", 236, 316, 16'h07E0);
    if (wa_q.size() == 16) check("br_last", wa_q[15], 32'd76799);

    // ena low in idle blocks acceptance; ena toggling during paint; touches in paint ignored
    clr_log();
    color = 16'h001F;
    set_touch(1'b1, 0, 0);
    ena = 1'b0;
    repeat (3) tick();
    check("enalo_writes", wa_q.size(), 32'd0);
    check("enalo_busy", {31'd0, busy_s}, 32'd0);
    ena = 1'b1;
    tick();
    color = 16'hAAAA;
    n = 0; hi_busy = 0;
    for (k = 0; k < 80; k++) begin
      ena = (k % 2 == 0);
      if (k == 3) set_touch(1'b1, 100, 100);
      if (k == 9) set_touch(1'b0, 100, 100);
      tick();
      if (busy_s !== 1'b1) break;
      n++;
      if (ena) hi_busy++;
    end
    ena = 1'b1;
    repeat (3) tick();
    check("tog_busy_cyc", n, 32'd31);
    check("tog_hi_cyc", hi_busy, 32'd16);
    check("tog_enalo_wr", ena_low_writes, 32'd0);
    check_paint("tog", 0, 0, 16'h001F);

`ifndef VRAM_PAINTER_CLEAR_REQ_EN
    // clear_req in idle has no effect without the option
    clr_log();
    clear_req = 1'b1;
    repeat (3) tick();
    clear_req = 1'b0;
    check("creq_idle_wr", wa_q.size(), 32'd0);
    check("creq_idle_busy", {31'd0, busy_s}, 32'd0);
`endif

    // clear_req pulsed during the 5th paint write
    clr_log();
    color = 16'hFFFF;
    set_touch(1'b1, 20, 20);
    tick();
    n = 0;
    for (k = 0; k < 40; k++) begin
      clear_req = (k == 4);
      tick();
      if (busy_s !== 1'b1) break;
      n++;
    end
    clear_req = 1'b0;
`ifndef VRAM_PAINTER_CLEAR_REQ_EN
    check("creq_busy_cyc", n, 32'd16);
    check_paint("creq", 20, 20, 16'hFFFF);
`else
    check("creq_busy_cyc", n, 32'd40);
    check("creq_cnt", wa_q.size(), 32'd40);
    for (int i = 0; i < 16 && i < wa_q.size(); i++) begin
      check("creq_paddr", wa_q[i], (20 + i / 4) * W + 20 + i % 4);
    end
    for (int i = 16; i < wa_q.size(); i++) begin
      check("creq_caddr", wa_q[i], i - 16);
      check("creq_cdata", wd_q[i], 32'd0);
    end
`endif

    // Reset in the middle of a paint restarts the blank from address 0
    set_touch(1'b1, 40, 40);
    color = 16'h1234;
    tick();
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd1);
    check("mid_rst_addr", vram_wr_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_busy", {31'd0, busy}, 32'd1);
    check("post_rst_wen", {31'd0, vram_wr_ena}, 32'd1);
    check("post_rst_addr", vram_wr_addr, 32'd0);
    check("post_rst_data", vram_wr_data, 32'd0);
    @(negedge clk);
    clr_log();
    repeat (3) tick();
    check("post_rst_cnt", wa_q.size(), 32'd3);
    for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
      check("post_rst_seq", wa_q[i], i + 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
